// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: word-by-word DMA copy sequencer (one read then one write per word) on a shared memory port.
// Optional abort support is compiled in by defining DMA_CTRL_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start; working registers hold the last transfer
// RD    | read request at working src, waiting for ack
// WR    | write request at working dst with buffered data, waiting for ack
// DONE  | one-cycle completion pulse, then back to IDLE
module dma_xfer_ctrl #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int CW        = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [CW-1:0] transfer_size,
    input  logic          start,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          done,
`ifdef DMA_CTRL_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic [CW-1:0] words_left
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] STEP = AW'(ADDR_STEP);

    state_t        state, state_nxt;
    logic [AW-1:0] src_r;
    logic [AW-1:0] dst_r;
    logic [DW-1:0] buf_r;
    logic [CW-1:0] cnt_r;
    logic          abort_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (transfer_size == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (mem_ack) begin
                    state_nxt = WR;
                end
            end
            WR: begin
                if (mem_ack) begin
                    state_nxt = ((cnt_r == CW'(1)) || abort_hit) ? DONE : RD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_r <= '0;
            dst_r <= '0;
            buf_r <= '0;
            cnt_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_r <= src_addr;
                        dst_r <= dst_addr;
                        cnt_r <= transfer_size;
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        buf_r <= mem_rdata;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        cnt_r <= cnt_r - CW'(1);
                        src_r <= src_r + STEP;
                        dst_r <= dst_r + STEP;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DMA_CTRL_ABORT_EN
    logic abort_pend;

    // An abort seen in the same cycle as the write ack still ends the transfer.
    assign abort_hit = abort_pend | abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        abort_pend <= 1'b0;
                        aborted    <= 1'b0;
                    end
                end
                RD: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                WR: begin
                    if (mem_ack && abort_hit) begin
                        abort_pend <= 1'b0;
                        aborted    <= 1'b1;
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    // Bus outputs decode only from registered state so nothing combinational leaks from inputs.
    always_comb begin
        mem_addr = '0;
        case (state)
            RD:      mem_addr = src_r;
            WR:      mem_addr = dst_r;
            default: mem_addr = '0;
        endcase
    end

    assign mem_req    = (state == RD) || (state == WR);
    assign mem_we     = (state == WR);
    assign mem_wdata  = buf_r;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign words_left = cnt_r;

endmodule
